// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the pipeline, mult/div, register-file write and pending-write query
// signals of regfile_wb_arbiter. The arbiter connects to the slave modport.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
);
  // Valid/ready: a transfer happens at a rising CLK edge when valid && ready.
  // Ready never depends on the matching valid, and a requester holds valid and
  // its payload stable until the transfer happens.
  logic              p_valid;
  logic [SEL_W-1:0]  p_sel;
  logic [DATA_W-1:0] p_dat;
  logic              p_ready;

  logic              m_valid;
  logic [SEL_W-1:0]  m_sel;
  logic [DATA_W-1:0] m_dat;
  logic              m_ready;

  logic              rf_wen;
  logic [SEL_W-1:0]  rf_wsel;
  logic [DATA_W-1:0] rf_wdat;

  logic [SEL_W-1:0]  q_sel;
  logic              q_hit;
  logic [DATA_W-1:0] q_dat;

  modport slave (
    input  p_valid, p_sel, p_dat, m_valid, m_sel, m_dat, q_sel,
    output p_ready, m_ready, rf_wen, rf_wsel, rf_wdat, q_hit, q_dat
  );

  modport master (
    output p_valid, p_sel, p_dat, m_valid, m_sel, m_dat, q_sel,
    input  p_ready, m_ready, rf_wen, rf_wsel, rf_wdat, q_hit, q_dat
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and a one-entry
// mult/div holding buffer. Define REGARB_QUERY_EN to build the pending-write query.
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 5
) (
  input  logic                 CLK,
  input  logic                 nRST,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              hold_valid;
  logic [SEL_W-1:0]  hold_sel;
  logic [DATA_W-1:0] hold_dat;
  logic [3:0]        starve_cnt;

  logic              rf_wen_q;
  logic [SEL_W-1:0]  rf_wsel_q;
  logic [DATA_W-1:0] rf_wdat_q;

  logic force_hold;
  logic p_grant;
  logic h_grant;
  logic squash;
  logic m_load;

  // Grant decision; the pipeline wins unless the held result has starved.
  always_comb begin
    force_hold = hold_valid && (starve_cnt == STARVE_LIM);
    p_grant    = bus.p_valid && !force_hold;
    h_grant    = !p_grant && hold_valid;
    squash     = p_grant && hold_valid && (bus.p_sel == hold_sel) && (bus.p_sel != '0);
    m_load     = bus.m_valid && !hold_valid;
  end

  assign bus.p_ready = !force_hold;
  assign bus.m_ready = !hold_valid;

  // Registered write port; select/data hold their value on idle cycles.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rf_wen_q  <= 1'b0;
      rf_wsel_q <= '0;
      rf_wdat_q <= '0;
    end else if (p_grant) begin
      rf_wen_q  <= (bus.p_sel != '0);
      rf_wsel_q <= bus.p_sel;
      rf_wdat_q <= bus.p_dat;
    end else if (h_grant) begin
      rf_wen_q  <= (hold_sel != '0);
      rf_wsel_q <= hold_sel;
      rf_wdat_q <= hold_dat;
    end else begin
      rf_wen_q  <= 1'b0;
    end
  end

  assign bus.rf_wen  = rf_wen_q;
  assign bus.rf_wsel = rf_wsel_q;
  assign bus.rf_wdat = rf_wdat_q;

  // A younger pipeline write to the same register makes the held result dead.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_valid <= 1'b0;
      hold_sel   <= '0;
      hold_dat   <= '0;
    end else if (h_grant || squash) begin
      hold_valid <= 1'b0;
    end else if (m_load) begin
      hold_valid <= 1'b1;
      hold_sel   <= bus.m_sel;
      hold_dat   <= bus.m_dat;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (!hold_valid || h_grant || squash) begin
      starve_cnt <= '0;
    end else if (p_grant && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef REGARB_QUERY_EN
  logic q_match;
  assign q_match   = hold_valid && (hold_sel == bus.q_sel) && (bus.q_sel != '0);
  assign bus.q_hit = q_match;
  assign bus.q_dat = q_match ? hold_dat : '0;
`else
  logic unused_q_sel;
  assign unused_q_sel = ^bus.q_sel;
  assign bus.q_hit    = 1'b0;
  assign bus.q_dat    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, pipeline writes, starvation,
// squash, idle drain, reset discard and the optional pending-write query.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 5;

  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_err;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus();

  regfile_wb_arbiter #(.STARVE_MAX(3), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // clock/reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p_valid = 1'b0; bus.p_sel = '0; bus.p_dat = '0;
    bus.m_valid = 1'b0; bus.m_sel = '0; bus.m_dat = '0;
    bus.q_sel   = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.p_valid = 1'b1; bus.p_sel = 5'd5; bus.p_dat = 32'h55AA;
    tick(); tick();
    n_cmp++; if (bus.rf_wen  !== 1'b0)  begin n_err++; $display("FAIL rst_wen got %0h want 0", bus.rf_wen); end
    n_cmp++; if (bus.rf_wsel !== 5'd0)  begin n_err++; $display("FAIL rst_wsel got %0h want 0", bus.rf_wsel); end
    n_cmp++; if (bus.rf_wdat !== 32'h0) begin n_err++; $display("FAIL rst_wdat got %0h want 0", bus.rf_wdat); end
    n_cmp++; if (bus.m_ready !== 1'b1)  begin n_err++; $display("FAIL rst_m_ready got %0h want 1", bus.m_ready); end
    n_cmp++; if (bus.p_ready !== 1'b1)  begin n_err++; $display("FAIL rst_p_ready got %0h want 1", bus.p_ready); end
    nRST = 1'b1;
    tick();
    n_cmp++; if (bus.rf_wen  !== 1'b1)     begin n_err++; $display("FAIL rel_wen got %0h want 1", bus.rf_wen); end
    n_cmp++; if (bus.rf_wsel !== 5'd5)     begin n_err++; $display("FAIL rel_wsel got %0h want 5", bus.rf_wsel); end
    n_cmp++; if (bus.rf_wdat !== 32'h55AA) begin n_err++; $display("FAIL rel_wdat got %0h want 55aa", bus.rf_wdat); end
    bus.p_valid = 1'b0;
    tick();
    n_cmp++; if (bus.rf_wen  !== 1'b0) begin n_err++; $display("FAIL idle_wen got %0h want 0", bus.rf_wen); end
    n_cmp++; if (bus.rf_wsel !== 5'd5) begin n_err++; $display("FAIL idle_wsel_hold got %0h want 5", bus.rf_wsel); end
  endtask

  task automatic test_pipeline();
    bus.p_valid = 1'b1; bus.p_sel = 5'd3; bus.p_dat = 32'hDEADBEEF;
    tick();
    n_cmp++; if (bus.rf_wen  !== 1'b1)         begin n_err++; $display("FAIL pipe_wen got %0h want 1", bus.rf_wen); end
    n_cmp++; if (bus.rf_wsel !== 5'd3)         begin n_err++; $display("FAIL pipe_wsel got %0h want 3", bus.rf_wsel); end
    n_cmp++; if (bus.rf_wdat !== 32'hDEADBEEF) begin n_err++; $display("FAIL pipe_wdat got %0h want deadbeef", bus.rf_wdat); end
    bus.p_sel = 5'd0; bus.p_dat = 32'h1111;
    n_cmp++; if (bus.p_ready !== 1'b1) begin n_err++; $display("FAIL r0_p_ready got %0h want 1", bus.p_ready); end
    tick();
    n_cmp++; if (bus.rf_wen  !== 1'b0)     begin n_err++; $display("FAIL r0_wen got %0h want 0", bus.rf_wen); end
    n_cmp++; if (bus.rf_wdat !== 32'h1111) begin n_err++; $display("FAIL r0_wdat got %0h want 1111", bus.rf_wdat); end
    bus.p_valid = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    bus.m_valid = 1'b1; bus.m_sel = 5'd8; bus.m_dat = 32'h1234;
    n_cmp++; if (bus.m_ready !== 1'b1) begin n_err++; $display("FAIL stv_m_ready0 got %0h want 1", bus.m_ready); end
    tick();
    bus.m_valid = 1'b0;
    n_cmp++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL stv_m_busy got %0h want 0", bus.m_ready); end
    bus.p_valid = 1'b1; bus.p_sel = 5'd9; bus.p_dat = 32'h900;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.p_ready !== 1'b1) begin n_err++; $display("FAIL stv_p_ready[%0d] got %0h want 1", i, bus.p_ready); end
      tick();
      n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd9) begin
        n_err++; $display("FAIL stv_pwrite[%0d] got wen=%0h sel=%0h want wen=1 sel=9", i, bus.rf_wen, bus.rf_wsel); end
    end
    n_cmp++; if (bus.p_ready !== 1'b0) begin n_err++; $display("FAIL stv_force got p_ready=%0h want 0", bus.p_ready); end
    tick();
    n_cmp++; if (bus.rf_wen  !== 1'b1)     begin n_err++; $display("FAIL stv_hwen got %0h want 1", bus.rf_wen); end
    n_cmp++; if (bus.rf_wsel !== 5'd8)     begin n_err++; $display("FAIL stv_hsel got %0h want 8", bus.rf_wsel); end
    n_cmp++; if (bus.rf_wdat !== 32'h1234) begin n_err++; $display("FAIL stv_hdat got %0h want 1234", bus.rf_wdat); end
    n_cmp++; if (bus.m_ready !== 1'b1)     begin n_err++; $display("FAIL stv_m_ready1 got %0h want 1", bus.m_ready); end
    n_cmp++; if (bus.p_ready !== 1'b1)     begin n_err++; $display("FAIL stv_p_ready1 got %0h want 1", bus.p_ready); end
    tick();
    n_cmp++; if (bus.rf_wsel !== 5'd9 || bus.rf_wdat !== 32'h900) begin
      n_err++; $display("FAIL stv_pretry got sel=%0h dat=%0h want sel=9 dat=900", bus.rf_wsel, bus.rf_wdat); end
    bus.p_valid = 1'b0;
    tick();
  endtask

  task automatic test_squash();
    bus.m_valid = 1'b1; bus.m_sel = 5'd7; bus.m_dat = 32'h1234;
    tick();
    bus.m_valid = 1'b0;
    bus.p_valid = 1'b1; bus.p_sel = 5'd7; bus.p_dat = 32'hA;
    tick();
    bus.p_valid = 1'b0;
    n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd7 || bus.rf_wdat !== 32'hA) begin
      n_err++; $display("FAIL sq_write got wen=%0h sel=%0h dat=%0h want 1/7/a", bus.rf_wen, bus.rf_wsel, bus.rf_wdat); end
    n_cmp++; if (bus.m_ready !== 1'b1) begin n_err++; $display("FAIL sq_cleared got m_ready=%0h want 1", bus.m_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.rf_wen !== 1'b0) begin n_err++; $display("FAIL sq_no_stale[%0d] got wen=%0h want 0", i, bus.rf_wen); end
    end
  endtask

  task automatic test_back_to_back();
    // different register: no squash, held result drains after the pipeline write
    bus.m_valid = 1'b1; bus.m_sel = 5'd10; bus.m_dat = 32'hB0;
    tick();
    bus.m_valid = 1'b0;
    bus.p_valid = 1'b1; bus.p_sel = 5'd6; bus.p_dat = 32'h60;
    tick();
    bus.p_valid = 1'b0;
    n_cmp++; if (bus.rf_wsel !== 5'd6 || bus.rf_wdat !== 32'h60) begin
      n_err++; $display("FAIL b2b_p got sel=%0h dat=%0h want 6/60", bus.rf_wsel, bus.rf_wdat); end
    n_cmp++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL b2b_still_held got m_ready=%0h want 0", bus.m_ready); end
    tick();
    n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd10 || bus.rf_wdat !== 32'hB0) begin
      n_err++; $display("FAIL b2b_h got wen=%0h sel=%0h dat=%0h want 1/a/b0", bus.rf_wen, bus.rf_wsel, bus.rf_wdat); end
    tick();
  endtask

  task automatic test_idle_drain();
    bus.m_valid = 1'b1; bus.m_sel = 5'd4; bus.m_dat = 32'h44;
    tick();
    bus.m_valid = 1'b0;
    n_cmp++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL drn_m_busy got %0h want 0", bus.m_ready); end
    n_cmp++; if (bus.rf_wen  !== 1'b0) begin n_err++; $display("FAIL drn_wen0 got %0h want 0", bus.rf_wen); end
    tick();
    n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd4 || bus.rf_wdat !== 32'h44) begin
      n_err++; $display("FAIL drn_write got wen=%0h sel=%0h dat=%0h want 1/4/44", bus.rf_wen, bus.rf_wsel, bus.rf_wdat); end
    n_cmp++; if (bus.m_ready !== 1'b1) begin n_err++; $display("FAIL drn_m_ready got %0h want 1", bus.m_ready); end
    tick();
  endtask

  task automatic test_reset_discard();
    bus.m_valid = 1'b1; bus.m_sel = 5'd20; bus.m_dat = 32'h2020;
    tick();
    bus.m_valid = 1'b0;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    n_cmp++; if (bus.m_ready !== 1'b1) begin n_err++; $display("FAIL rdis_m_ready got %0h want 1", bus.m_ready); end
    tick();
    n_cmp++; if (bus.rf_wen !== 1'b0) begin n_err++; $display("FAIL rdis_no_write got wen=%0h want 0", bus.rf_wen); end
  endtask

  task automatic test_query();
    logic              exp_hit;
    logic [DATA_W-1:0] exp_dat;
`ifdef REGARB_QUERY_EN
    exp_hit = 1'b1; exp_dat = 32'h55;
`else
    exp_hit = 1'b0; exp_dat = 32'h0;
`endif
    bus.m_valid = 1'b1; bus.m_sel = 5'd12; bus.m_dat = 32'h55;
    tick();
    bus.m_valid = 1'b0;
    bus.q_sel = 5'd12; #1;
    n_cmp++; if (bus.q_hit !== exp_hit) begin n_err++; $display("FAIL q12_hit got %0h want %0h", bus.q_hit, exp_hit); end
    n_cmp++; if (bus.q_dat !== exp_dat) begin n_err++; $display("FAIL q12_dat got %0h want %0h", bus.q_dat, exp_dat); end
    bus.q_sel = 5'd0; #1;
    n_cmp++; if (bus.q_hit !== 1'b0 || bus.q_dat !== 32'h0) begin
      n_err++; $display("FAIL q0 got hit=%0h dat=%0h want 0/0", bus.q_hit, bus.q_dat); end
    bus.q_sel = 5'd13; #1;
    n_cmp++; if (bus.q_hit !== 1'b0 || bus.q_dat !== 32'h0) begin
      n_err++; $display("FAIL q13 got hit=%0h dat=%0h want 0/0", bus.q_hit, bus.q_dat); end
    bus.q_sel = 5'd12;
    tick();
    n_cmp++; if (bus.q_hit !== 1'b0) begin n_err++; $display("FAIL q_after_drain got %0h want 0", bus.q_hit); end
    bus.q_sel = 5'd0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nRST  = 1'b0;
    idle_inputs();
    test_reset();
    test_pipeline();
    test_starvation();
    test_squash();
    test_back_to_back();
    test_idle_drain();
    test_reset_discard();
    test_query();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WEN/wsel/wdat) between two writers: the in-order pipeline writeback stage and the long-latency mult/div unit.
- Mult/div results are captured in a one-entry holding buffer.
- The pipeline has priority, bounded by a starvation counter.
- The write port is driven from a registered output stage; the register file commits on the following negedge of CLK.

Parameters:
- STARVE_MAX, 3: cycles a held mult/div result may lose arbitration before it is forced through (1..15).
- DATA_W, 32: write data width.
- SEL_W, 5: register select width.

Ports:
- CLK  in  1  clock, rising-edge
- nRST  in  1  synchronous, active-low reset
- p_valid  in  1  pipeline write request
- p_sel  in  SEL_W  pipeline destination register
- p_dat  in  DATA_W  pipeline write data
- p_ready  out  1  pipeline request accepted this cycle
- m_valid  in  1  mult/div result valid
- m_sel  in  SEL_W  mult/div destination register
- m_dat  in  DATA_W  mult/div data
- m_ready  out  1  holding buffer can accept
- rf_wen  out  1  to register file WEN
- rf_wsel  out  SEL_W  to register file wsel
- rf_wdat  out  DATA_W  to register file wdat
- q_sel  in  SEL_W  pending-write query select (feature only)
- q_hit  out  1  query hit (feature only)
- q_dat  out  DATA_W  query data (feature only)

Behaviour:
- Interface: one clock, CLK; reset nRST is synchronous and active-low.
- Reset (nRST=0 at a rising edge):
  - rf_wen=0, rf_wsel=0, rf_wdat=0.
  - hold_valid=0, hold_sel=0, hold_dat=0, starve_cnt=0.
  - A held result is discarded on reset mid-operation.
- Handshakes:
  - Pipeline handshake: p_valid && p_ready.
  - Mult/div handshake: m_valid && m_ready.
  - Inputs are sampled at the rising edge.
- m_ready = !hold_valid. The buffer cannot refill in the same cycle it drains, so mult/div throughput is at most 1 per 2 cycles.
- force = hold_valid && (starve_cnt == STARVE_MAX).
- p_ready = !force. p_ready depends on state only, never on p_valid.
- Grant, evaluated each cycle:
  - p_valid && !force: pipeline granted.
  - Else if hold_valid: hold granted.
  - Else: no grant.
- Output stage, registered, 1-cycle latency from grant:
  - On grant of (sel, dat): next rf_wsel=sel, rf_wdat=dat, rf_wen=(sel!=0).
  - No grant: rf_wen=0; rf_wsel/rf_wdat hold their previous values.
  - Writes to register 0 complete the handshake but never assert rf_wen.
- Holding buffer:
  - Loads m_sel/m_dat on the mult/div handshake.
  - Clears on hold grant.
- Squash rule: pipeline writes are always younger in program order than a held result.
  - If the pipeline is granted with p_sel == hold_sel and p_sel != 0, the held entry is dropped (hold_valid=0, starve_cnt=0) without being written.
  - Comparison is against buffer contents before any same-cycle load. Since m_ready=0 while hold_valid=1, a load and a squash never coincide.
- starve_cnt:
  - Reset to 0 on hold grant, squash, or hold_valid=0.
  - Incremented when hold_valid && pipeline granted (saturates at STARVE_MAX).
  - Unchanged otherwise.
- Simultaneous p_valid and held entry with force=1: hold granted, p_ready=0. The pipeline must hold its request stable and is granted the next cycle.

Optional Feature:
- Macro: REGARB_QUERY_EN.
- Defined:
  - q_hit = hold_valid && (hold_sel == q_sel) && (q_sel != 0), combinational.
  - q_dat = hold_dat when q_hit, else 0.
  - Used by hazard logic to see a result that is held but not yet written.
- Undefined: ports remain; q_hit=0 and q_dat=0 constantly, and the compare logic is not built.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with p_valid=1, p_sel=5 → rf_wen=0, m_ready=1, p_ready=1. Release reset → rf_wen=1, rf_wsel=5 one cycle later.
- Pipeline-only: p_valid=1, sel=3, dat=0xDEADBEEF → next cycle rf_wen=1, rf_wsel=3, rf_wdat=0xDEADBEEF. Sel=0 → handshake completes, rf_wen=0.
- Starvation (STARVE_MAX=3): load m (sel=8, dat=0x1234), then hold p_valid=1 (sel=9) continuously → p granted 3 cycles, then p_ready=0 for 1 cycle and rf_wsel=8, rf_wdat=0x1234 the following cycle. m_ready returns to 1.
- Squash: hold sel=7, then p_valid with sel=7, dat=0xA → rf_wdat=0xA written once, hold_valid cleared, 0x1234-style held value never written.
- Idle drain: load m (sel=4) with p_valid=0 → rf_wen=1, rf_wsel=4 two cycles after m handshake; m_ready low for exactly 1 cycle.
- REGARB_QUERY_EN: hold sel=12, dat=0x55; q_sel=12 → q_hit=1, q_dat=0x55. q_sel=0 or 13 → q_hit=0. Without the macro, q_hit=0 always.
